// File: rtl/serial_nibble_adder_pkg.sv
// Shared types and constants for the serial nibble adder.
package serial_nibble_adder_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Counter width for NIBBLES add cycles; never below one bit.
  function automatic int cnt_w(input int nibbles);
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction
endpackage

// File: rtl/serial_nibble_adder_nib.sv
// Combinational 4-bit ripple-carry adder used as the per-cycle slice.
module nibble_adder
  import serial_nibble_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);
  logic [NIBBLE_W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[NIBBLE_W];
  end
endmodule

// File: rtl/serial_nibble_adder.sv
// WIDTH-bit adder that sums one nibble per clock through a single nibble_adder.
// Optional signed-overflow output enabled by SERIAL_NIBBLE_ADDER_OVERFLOW_EN.
module serial_nibble_adder
  import serial_nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_NIBBLE_ADDER_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CW      = cnt_w(NIBBLES);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("serial_nibble_adder: WIDTH must be a multiple of 4 and >= 8");
  end

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    a_sh, b_sh, res_sh, res_nxt;
  logic                carry;
  logic [CW-1:0]       cnt;
  logic                last;
  logic [NIBBLE_W-1:0] nsum;
  logic                ncout;

  nibble_adder u_nib (
    .a   (a_sh[NIBBLE_W-1:0]),
    .b   (b_sh[NIBBLE_W-1:0]),
    .cin (carry),
    .sum (nsum),
    .cout(ncout)
  );

  // Result fills from the top so the LSB nibble lands at bit 0 after NIBBLES shifts.
  assign res_nxt = {nsum, res_sh[WIDTH-1:NIBBLE_W]};
  assign last    = (cnt == CW'(NIBBLES - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

`ifdef SERIAL_NIBBLE_ADDER_OVERFLOW_EN
  logic [1:0] msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msb <= '0;
      ovf <= 1'b0;
    end else if (state == IDLE && start) begin
      msb <= {a[WIDTH-1], b[WIDTH-1]};
    end else if (state == RUN && last) begin
      // Carry into the MSB recovered from operand MSBs and the final sum bit.
      ovf <= msb[1] ^ msb[0] ^ res_nxt[WIDTH-1] ^ ncout;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      busy <= (state_nxt == RUN);
      done <= (state == RUN) && last;
      case (state)
        IDLE: if (start) begin
          a_sh  <= a;
          b_sh  <= b;
          carry <= cin;
          cnt   <= '0;
        end
        RUN: begin
          a_sh   <= a_sh >> NIBBLE_W;
          b_sh   <= b_sh >> NIBBLE_W;
          res_sh <= res_nxt;
          carry  <= ncout;
          cnt    <= cnt + CW'(1);
          if (last) begin
            sum  <= res_nxt;
            cout <= ncout;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_nibble_adder.sv
// Scoreboard bench for serial_nibble_adder (WIDTH=16) with randomized operands.
module tb_serial_nibble_adder;
  localparam int W       = 16;
  localparam int NIBBLES = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] ai, bi;
  logic         cini;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_NIBBLE_ADDER_OVERFLOW_EN
  logic         ovf;
`endif

  serial_nibble_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (ai),
    .b    (bi),
    .cin  (cini),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
`ifdef SERIAL_NIBBLE_ADDER_OVERFLOW_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           cyc;
  } exp_t;

  exp_t         q[$];
  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  logic [W-1:0] last_s;
  logic         last_co;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the full operands.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t e;
    logic [W:0] full;
    int sx, sy, ss;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    e.s  = full[W-1:0];
    e.co = full[W];
    sx   = int'($signed(x));
    sy   = int'($signed(y));
    ss   = sx + sy + int'(c);
    e.ov = (ss > (2 ** (W - 1)) - 1) || (ss < -(2 ** (W - 1)));
    e.cyc = 0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending request (t=%0t)", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("cout", 32'(cout), 32'(e.co));
        chk("latency", 32'(cyc), 32'(e.cyc + NIBBLES));
        chk("busy_at_done", 32'(busy), 32'd0);
`ifdef SERIAL_NIBBLE_ADDER_OVERFLOW_EN
        chk("ovf", 32'(ovf), 32'(e.ov));
`endif
        last_s  = e.s;
        last_co = e.co;
      end
    end
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t e;
    @(negedge clk);
    ai = x; bi = y; cini = c; start = 1'b1;
    @(posedge clk);
    #1;
    e = model(x, y, c);
    e.cyc = cyc;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    ai = W'($urandom); bi = W'($urandom); cini = 1'($urandom);
    chk("busy_run", 32'(busy), 32'd1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ai = '0; bi = '0; cini = 1'b0;
    last_s = '0; last_co = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(16'h1234, 16'h0FCD, 1'b0); wait_done();
    issue(16'hFFFF, 16'h0001, 1'b0); wait_done();
    issue(16'h0000, 16'h0000, 1'b1); wait_done();
    issue(16'hFFFF, 16'hFFFF, 1'b1); wait_done();
    issue(16'h7FFF, 16'h0001, 1'b0); wait_done();
    issue(16'h8000, 16'h8000, 1'b0); wait_done();

    // Results hold while idle, regardless of operand activity.
    repeat (3) begin
      @(negedge clk);
      ai = W'($urandom); bi = W'($urandom);
      chk("hold_sum", 32'(sum), 32'(last_s));
      chk("hold_cout", 32'(cout), 32'(last_co));
    end

    // Starts during RUN and DONE are ignored; the monitor flags any extra done.
    issue(16'h0001, 16'h0001, 1'b0);
    ai = 16'h1111; bi = 16'h1111; start = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);
    chk("ignored_sum", 32'(sum), 32'h0002);

    // Reset mid-operation aborts without a done pulse.
    issue(16'hABCD, 16'h1234, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(16'h0F0F, 16'hF0F1, 1'b0); wait_done();

    for (int i = 0; i < 30; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule
